leds_red_blinker: RTL and testbench
===================================

Name: leds_red_blinker

Overview:
- Downstream of the red-LED PIO: consumes its 18-bit level word and produces the conditioned word that drives the board LEDR pins.
- Adds per-LED blink, so the traffic-light controller can flash pedestrian and fault LEDs without CPU polling.
- Configured over a small Avalon-MM slave on the same bus as the PIO.
- Optional global PWM dimming.

Parameters:
- LED_W, 18, LED word width (matches the PIO).
- HALF_PERIOD_RST, 25000000, reset value of the blink half-period register in clk cycles (0.5 s at 50 MHz).
- PWM_DUTY_RST, 255, reset duty value (only used when LEDS_PWM_EN is defined).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- led_in  in  LED_W  level word from the PIO out_port.
- address  in  2  Avalon register select.
- chipselect  in  1  Avalon select.
- write_n  in  1  Avalon write strobe, active-low.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data; combinational from address, zero-extended.
- led_out  out  LED_W  conditioned LED drive, registered.

Behaviour:
- Reset and clocking:
  - One clock; reset is asynchronous and active-high.
  - All state clears on reset assertion regardless of clk.
- Register map (write when chipselect && !write_n; no wait states):
  - addr 0, BLINK_MASK[LED_W-1:0]: bit=1 makes that LED blink. Reset 0.
  - addr 1, HALF_PERIOD[31:0]: reset HALF_PERIOD_RST.
  - addr 2, PWM_DUTY[7:0]: see Optional Feature.
  - addr 3, STATUS (read-only): bit0 = blink phase, bits[LED_W:1] = current led_out. Writes ignored.
- Reads to unused bits return 0.
- Blink timer:
  - 32-bit counter cnt increments every clk.
  - When cnt == HALF_PERIOD-1: cnt <= 0 and phase toggles.
  - HALF_PERIOD == 0: timer frozen, cnt = 0, phase = 1 (blinking LEDs held ON).
  - Any write to addr 1: cnt <= 0 and phase <= 1 in the same edge; the new period applies from the next cycle.
- Reset values: phase = 1, cnt = 0.
- Output: led_out <= led_in & (~BLINK_MASK | {LED_W{phase}}) & {LED_W{pwm_gate}}.
  - One-cycle latency from led_in, mask, or phase to led_out.
  - led_out resets to 0.
- Simultaneous events:
  - A mask write on the same edge as a phase toggle: both take effect together; led_out reflects them one cycle later.
  - A period write on the same edge as a terminal count: the write wins (phase forced to 1).
- led_in is assumed synchronous to clk; no synchronizer is required.

Optional Feature:
- Macro: LEDS_PWM_EN.
- Defined:
  - 8-bit free-running pwm_cnt, reset 0, wraps 255->0.
  - pwm_gate = (PWM_DUTY == 255) | (pwm_cnt < PWM_DUTY).
  - Duty 0 means always off; 255 means always on.
  - PWM_DUTY resets to PWM_DUTY_RST and is read/write at addr 2.
- Not defined:
  - pwm_gate = 1.
  - addr 2 reads 0 and writes are ignored.
  - No pwm_cnt logic is synthesised.

Decomposition:
- Package leds_pkg holds:
  - LED_W.
  - Address constants ADDR_MASK=0, ADDR_PERIOD=1, ADDR_DUTY=2, ADDR_STATUS=3.
  - STATUS bit positions.
- Sub-module blink_timer holds cnt and phase.
  - Inputs: half_period, restart.
  - Output: phase.
- Register file and output stage stay in the top module.

Test Plan:
- Reset mid-run: assert reset with led_out=0x3FFFF -> led_out=0, readdata@0=0, readdata@1=25000000 before the next clk edge.
- Passthrough: mask=0, led_in=0x2A5A5 -> led_out=0x2A5A5 exactly one cycle later; STATUS[18:1]=0x2A5A5.
- Blink: period=4, mask=0x00003, led_in=0x3FFFF -> bits[1:0] are 1 for 4 cycles and 0 for 4 cycles, repeating; bits[17:2] are steady 1.
- Period 0: write period=0 during OFF phase -> phase=1 next cycle and blinking bits stay 1 indefinitely.
- Restart collision: write period=3 on the terminal-count edge of period=4 -> phase=1, and the next toggle occurs 3 cycles after the write.
- PWM (LEDS_PWM_EN): duty=64, mask=0, led_in=0x00001 -> bit0 high for exactly 64 of each 256 cycles; duty=0 gives always 0; duty=255 gives always 1; without the macro, addr 2 reads 0.

Source files
------------

// File: rtl/leds_pkg.sv
// rtl/leds_pkg.sv - shared constants for the red-LED blinker
// Holds the default LED word width, the register addresses of the Avalon
// slave and the bit positions inside the STATUS register.
package leds_pkg;

  localparam int LED_W = 18;

  localparam logic [1:0] ADDR_MASK   = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_DUTY   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  // STATUS layout: bit0 = blink phase, bits[LED_W:1] = current led_out
  localparam int STATUS_PHASE_BIT = 0;
  localparam int STATUS_LED_LSB   = 1;

endpackage

// File: rtl/blink_timer.sv
// rtl/blink_timer.sv - half-period counter producing the blink phase
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous active-high reset
//   half_period in   [31:0] phase half-period in clk cycles (0 = frozen ON)
//   restart     in   clears the count and forces phase ON this edge
//   phase       out  blink phase, 1 = blinking LEDs lit
module blink_timer
  import leds_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] half_period,
  input  logic        restart,
  output logic        phase
);

  logic [31:0] cnt_q, cnt_d;
  logic        phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q + 32'd1;
    phase_d = phase_q;
    // A period write takes priority over a terminal count on the same edge;
    // a zero period parks the timer with the blinking LEDs held on.
    if (restart || (half_period == 32'd0)) begin
      cnt_d   = 32'd0;
      phase_d = 1'b1;
    end else if (cnt_q == (half_period - 32'd1)) begin
      cnt_d   = 32'd0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= 32'd0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/leds_red_blinker.sv
// rtl/leds_red_blinker.sv - per-LED blink and optional PWM dimming of the red LED word
// Optional feature macro: LEDS_PWM_EN (global PWM dimming, duty register at addr 2).
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-high reset
//   led_in     in   [LED_W-1:0] level word from the PIO
//   address    in   [1:0] register select
//   chipselect in   slave select
//   write_n    in   active-low write strobe
//   writedata  in   [31:0] write data
//   readdata   out  [31:0] combinational read data, zero-extended
//   led_out    out  [LED_W-1:0] registered LED drive
module leds_red_blinker
  import leds_pkg::*;
#(
  parameter int          LED_W           = leds_pkg::LED_W,
  parameter logic [31:0] HALF_PERIOD_RST = 32'd25000000,
  parameter logic [7:0]  PWM_DUTY_RST    = 8'd255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LED_W-1:0] led_in,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [LED_W-1:0] led_out
);

  logic             wr_en;
  logic [LED_W-1:0] mask_q, mask_d;
  logic [31:0]      period_q, period_d;
  logic [LED_W-1:0] led_out_q, led_out_d;
  logic             phase;
  logic             restart;
  logic             pwm_gate;
  logic [31:0]      duty_rd;
  logic [31:0]      mask_rd;
  logic [31:0]      status_rd;

  assign wr_en   = chipselect && !write_n;
  assign restart = wr_en && (address == ADDR_PERIOD);

  blink_timer u_blink_timer (
    .clk         (clk),
    .reset       (reset),
    .half_period (period_q),
    .restart     (restart),
    .phase       (phase)
  );

`ifdef LEDS_PWM_EN
  logic [7:0] duty_q, duty_d;
  logic [7:0] pwm_cnt_q;

  always_comb begin
    duty_d = duty_q;
    if (wr_en && (address == ADDR_DUTY)) duty_d = writedata[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_q    <= PWM_DUTY_RST;
      pwm_cnt_q <= 8'd0;
    end else begin
      duty_q    <= duty_d;
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
    end
  end

  // Duty 255 must be fully on, which the compare alone cannot express.
  assign pwm_gate = (duty_q == 8'hFF) | (pwm_cnt_q < duty_q);
  assign duty_rd  = {24'd0, duty_q};
`else
  logic [7:0] unused_pwm_duty_rst;

  assign unused_pwm_duty_rst = PWM_DUTY_RST;
  assign pwm_gate            = 1'b1;
  assign duty_rd             = 32'd0;
`endif

  always_comb begin
    mask_d    = mask_q;
    period_d  = period_q;
    if (wr_en && (address == ADDR_MASK))   mask_d   = writedata[LED_W-1:0];
    if (wr_en && (address == ADDR_PERIOD)) period_d = writedata;
    led_out_d = led_in & (~mask_q | {LED_W{phase}}) & {LED_W{pwm_gate}};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q    <= '0;
      period_q  <= HALF_PERIOD_RST;
      led_out_q <= '0;
    end else begin
      mask_q    <= mask_d;
      period_q  <= period_d;
      led_out_q <= led_out_d;
    end
  end

  always_comb begin
    mask_rd                                = 32'd0;
    mask_rd[LED_W-1:0]                     = mask_q;
    status_rd                              = 32'd0;
    status_rd[STATUS_PHASE_BIT]            = phase;
    status_rd[STATUS_LED_LSB +: LED_W]     = led_out_q;
  end

  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_MASK:   readdata = mask_rd;
      ADDR_PERIOD: readdata = period_q;
      ADDR_DUTY:   readdata = duty_rd;
      ADDR_STATUS: readdata = status_rd;
      default:     readdata = 32'd0;
    endcase
  end

  assign led_out = led_out_q;

endmodule

// File: tb/tb_leds_red_blinker.sv
// tb/tb_leds_red_blinker.sv - directed self-checking bench for leds_red_blinker
module tb_leds_red_blinker;

  logic        clk;
  logic        reset;
  logic [17:0] led_in;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [17:0] led_out;

  int n_checks = 0;
  int n_errors = 0;

  leds_red_blinker dut (
    .clk        (clk),
    .reset      (reset),
    .led_in     (led_in),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .led_out    (led_out)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; the write lands on the following posedge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [31:0] r;
  logic [17:0] exp_led;
  int          ones;

  initial begin
    reset      = 1'b1;
    led_in     = '0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    #3;
    check("rst_led_out", {14'd0, led_out}, 32'd0);
    rd(2'd0, r); check("rst_mask", r, 32'd0);
    rd(2'd1, r); check("rst_period", r, 32'd25000000);
    rd(2'd3, r); check("rst_status", r, 32'd1);
    @(negedge clk);
    reset = 1'b0;

    // Passthrough with one-cycle latency
    led_in = 18'h2A5A5;
    check("pass_latency", {14'd0, led_out}, 32'd0);
    tick(1);
    check("pass_led_out", {14'd0, led_out}, 32'h2A5A5);
    rd(2'd3, r); check("pass_status", r, 32'h54B4B);

    // Blink: period 4 on bits[1:0]
    led_in = 18'h3FFFF;
    wr(2'd0, 32'h3);
    wr(2'd1, 32'd4);
    check("blink_k0", {14'd0, led_out}, 32'h3FFFF);
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      exp_led = ((((k - 1) / 4) % 2) == 0) ? 18'h3FFFF : 18'h3FFFC;
      check($sformatf("blink_led_k%0d", k), {14'd0, led_out}, {14'd0, exp_led});
      rd(2'd3, r);
      check($sformatf("blink_phase_k%0d", k), {31'd0, r[0]}, {31'd0, (((k / 4) % 2) == 0)});
    end

    // Period 0 written during OFF phase
    wr(2'd1, 32'd0);
    rd(2'd3, r); check("p0_phase_on", {31'd0, r[0]}, 32'd1);
    check("p0_led_lag", {14'd0, led_out}, 32'h3FFFC);
    rd(2'd1, r); check("p0_period_rd", r, 32'd0);
    for (int k = 0; k < 10; k++) begin
      tick(1);
      check($sformatf("p0_hold_%0d", k), {14'd0, led_out}, 32'h3FFFF);
    end

    // Restart collision: period 3 written on terminal-count edge of period 4
    wr(2'd1, 32'd4);
    tick(3);
    rd(2'd3, r); check("coll_pre_phase", {31'd0, r[0]}, 32'd1);
    wr(2'd1, 32'd3);
    rd(2'd3, r); check("coll_w0", {31'd0, r[0]}, 32'd1);
    tick(1); rd(2'd3, r); check("coll_w1", {31'd0, r[0]}, 32'd1);
    tick(1); rd(2'd3, r); check("coll_w2", {31'd0, r[0]}, 32'd1);
    tick(1); rd(2'd3, r); check("coll_w3", {31'd0, r[0]}, 32'd0);
    tick(2); rd(2'd3, r); check("coll_w5", {31'd0, r[0]}, 32'd0);
    tick(1); rd(2'd3, r); check("coll_w6", {31'd0, r[0]}, 32'd1);

    // STATUS is read-only
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd0, r); check("status_wr_mask", r, 32'h3);
    rd(2'd1, r); check("status_wr_period", r, 32'd3);

`ifdef LEDS_PWM_EN
    rd(2'd2, r); check("pwm_duty_rst", r, 32'd255);
    wr(2'd0, 32'h0);
    led_in = 18'h00001;
    wr(2'd2, 32'd64);
    rd(2'd2, r); check("pwm_duty_rd", r, 32'd64);
    tick(2);
    ones = 0;
    for (int k = 0; k < 256; k++) begin tick(1); ones += int'(led_out[0]); end
    check("pwm_duty64", ones, 32'd64);
    wr(2'd2, 32'd0);
    tick(2);
    ones = 0;
    for (int k = 0; k < 256; k++) begin tick(1); ones += int'(led_out[0]); end
    check("pwm_duty0", ones, 32'd0);
    wr(2'd2, 32'd255);
    tick(2);
    ones = 0;
    for (int k = 0; k < 256; k++) begin tick(1); ones += int'(led_out[0]); end
    check("pwm_duty255", ones, 32'd256);
    wr(2'd0, 32'h3);
    led_in = 18'h3FFFF;
`else
    wr(2'd2, 32'hFF);
    rd(2'd2, r); check("duty_absent_rd", r, 32'd0);
`endif

    // Reset mid-run with all LEDs lit
    wr(2'd1, 32'd0);
    tick(1);
    check("mid_pre_led", {14'd0, led_out}, 32'h3FFFF);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_led", {14'd0, led_out}, 32'd0);
    rd(2'd0, r); check("mid_rst_mask", r, 32'd0);
    rd(2'd1, r); check("mid_rst_period", r, 32'd25000000);
    rd(2'd3, r); check("mid_rst_status", r, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    tick(1);
    check("post_rst_led", {14'd0, led_out}, 32'h3FFFF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
